fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_if.sv | 13 +
 rtl/fetch_stage.sv | 141 ++++++++++++++
 tb/tb_fetch_stage.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
// Handshake: a transfer happens in any cycle where InstrReq and InstrRdy are
// both high; InstrRdata is only meaningful in that cycle. While InstrReq is
// high and InstrRdy is low, the requester keeps InstrAddr stable.
interface fetch_stage_if;
   logic        InstrReq;
   logic [31:0] InstrAddr;
   logic        InstrRdy;
   logic [31:0] InstrRdata;

   modport master (output InstrReq, output InstrAddr, input InstrRdy, input InstrRdata);
   modport slave  (input InstrReq, input InstrAddr, output InstrRdy, output InstrRdata);
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage: owns PCF, issues instruction requests and fills the IF/ID
// register. A one-entry buffer parks a word returned during a stall (HOLD),
// and a redirect register remembers a branch target that arrives while a
// request is still outstanding (DRAIN).
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h00000000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 StallF,
   input  logic                 StallD,
   input  logic                 PCSrcD,
   input  logic [31:0]          PCBranchD,
   fetch_stage_if.master        imem,
   output logic [31:0]          InstrD,
   output logic [31:0]          PCPlus4D,
   output logic                 ValidD,
   output logic [1:0]           stateDbg
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } fetchState_t;

   fetchState_t state, stateNext;
   logic [31:0] pcF, pcFNext, pcPlus4F;
   logic [31:0] instrDNext, pcPlus4DNext;
   logic        validDNext;
   logic [31:0] bufInstr, bufInstrNext, bufPcPlus4, bufPcPlus4Next;
   logic [31:0] redirPc, redirPcNext;
   logic        stall, redirect, xfer;

   // Request side: no request while parked in HOLD or while reset is held.
   assign imem.InstrReq  = (state != HOLD) & ~reset;
   assign imem.InstrAddr = pcF;
   assign stateDbg       = state;

   assign stall    = StallF | StallD;
   // A branch is only honoured when Decode itself is not stalled.
   assign redirect = PCSrcD & ~StallD;
   assign xfer     = imem.InstrReq & imem.InstrRdy;
   assign pcPlus4F = pcF + 32'd4;

   // Next-state and next-register values for every fetch state.
   always_comb begin
      stateNext      = state;
      pcFNext        = pcF;
      instrDNext     = InstrD;
      pcPlus4DNext   = PCPlus4D;
      validDNext     = ValidD;
      bufInstrNext   = bufInstr;
      bufPcPlus4Next = bufPcPlus4;
      redirPcNext    = redirPc;
      case (state)
         FETCH: begin
            if (redirect) begin
               // Flush IF/ID; a returned word belongs to the wrong path.
               instrDNext   = 32'd0;
               pcPlus4DNext = 32'd0;
               validDNext   = 1'b0;
               if (xfer) begin
                  pcFNext = PCBranchD;
               end else begin
                  redirPcNext = PCBranchD;
                  stateNext   = DRAIN;
               end
            end else if (xfer) begin
               if (stall) begin
                  bufInstrNext   = imem.InstrRdata;
                  bufPcPlus4Next = pcPlus4F;
                  stateNext      = HOLD;
               end else begin
                  pcFNext      = pcPlus4F;
                  instrDNext   = imem.InstrRdata;
                  pcPlus4DNext = pcPlus4F;
                  validDNext   = 1'b1;
               end
            end else if (!StallD) begin
               instrDNext   = 32'd0;
               pcPlus4DNext = 32'd0;
               validDNext   = 1'b0;
            end
         end
         HOLD: begin
            if (redirect) begin
               pcFNext      = PCBranchD;
               instrDNext   = 32'd0;
               pcPlus4DNext = 32'd0;
               validDNext   = 1'b0;
               stateNext    = FETCH;
            end else if (!stall) begin
               instrDNext   = bufInstr;
               pcPlus4DNext = bufPcPlus4;
               validDNext   = 1'b1;
               pcFNext      = pcPlus4F;
               stateNext    = FETCH;
            end
         end
         DRAIN: begin
            if (!StallD) begin
               instrDNext   = 32'd0;
               pcPlus4DNext = 32'd0;
               validDNext   = 1'b0;
            end
            // Latest branch target wins, including one arriving with the drain.
            if (redirect) redirPcNext = PCBranchD;
            if (xfer) begin
               pcFNext   = redirect ? PCBranchD : redirPc;
               stateNext = FETCH;
            end
         end
         default: stateNext = FETCH;
      endcase
   end

   // State register; synchronous reset drops anything in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= FETCH;
         pcF        <= RESET_PC;
         InstrD     <= 32'd0;
         PCPlus4D   <= 32'd0;
         ValidD     <= 1'b0;
         bufInstr   <= 32'd0;
         bufPcPlus4 <= 32'd0;
         redirPc    <= 32'd0;
      end else begin
         state      <= stateNext;
         pcF        <= pcFNext;
         InstrD     <= instrDNext;
         PCPlus4D   <= pcPlus4DNext;
         ValidD     <= validDNext;
         bufInstr   <= bufInstrNext;
         bufPcPlus4 <= bufPcPlus4Next;
         redirPc    <= redirPcNext;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios followed by random traffic,
// all checked against a queue-based reference model of the fetch rules.
module tb_fetch_stage;

   localparam logic [31:0] RESET_PC = 32'h00000000;

   logic        clk;
   logic        reset;
   logic        StallF, StallD, PCSrcD;
   logic [31:0] PCBranchD;
   logic [31:0] InstrD, PCPlus4D;
   logic        ValidD;
   logic [1:0]  stateDbg;

   fetch_stage_if memIf ();

   fetch_stage #(.RESET_PC(RESET_PC)) dut (
      .clk       (clk),
      .reset     (reset),
      .StallF    (StallF),
      .StallD    (StallD),
      .PCSrcD    (PCSrcD),
      .PCBranchD (PCBranchD),
      .imem      (memIf.master),
      .InstrD    (InstrD),
      .PCPlus4D  (PCPlus4D),
      .ValidD    (ValidD),
      .stateDbg  (stateDbg)
   );

   // Clock generation.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int testCount = 0;
   int failCount = 0;

   // Reference model: fetch PC, IF/ID contents, a queue holding a word parked
   // during a stall, and a queue holding a pending branch target.
   logic [31:0] mPc;
   logic [31:0] mInstrD, mPcPlus4D;
   logic        mValidD;
   logic [31:0] mBufQ[$];
   logic [31:0] mRedirQ[$];

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      testCount++;
      if (got !== exp) begin
         failCount++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic modelReset();
      mPc       = RESET_PC;
      mInstrD   = 32'd0;
      mPcPlus4D = 32'd0;
      mValidD   = 1'b0;
      mBufQ.delete();
      mRedirQ.delete();
   endtask

   task automatic modelStep(input logic rst, input logic stF, input logic stD, input logic src,
                            input logic [31:0] tgt, input logic rdy, input logic [31:0] data);
      logic stall, redir, req, xfer;
      if (rst) begin
         modelReset();
         return;
      end
      stall = stF | stD;
      redir = src & !stD;
      req   = (mBufQ.size() == 0);
      xfer  = req & rdy;
      // IF/ID update
      if (!stD) begin
         if (redir || mRedirQ.size() != 0) begin
            mInstrD = 0; mPcPlus4D = 0; mValidD = 0;
         end else if (mBufQ.size() != 0) begin
            if (!stall) begin
               mInstrD = mBufQ[0]; mPcPlus4D = mPc + 4; mValidD = 1;
            end
         end else if (xfer) begin
            if (!stall) begin
               mInstrD = data; mPcPlus4D = mPc + 4; mValidD = 1;
            end
         end else begin
            mInstrD = 0; mPcPlus4D = 0; mValidD = 0;
         end
      end
      // PC and pending-work update
      if (mRedirQ.size() != 0) begin
         if (redir) mRedirQ[0] = tgt;
         if (xfer) mPc = mRedirQ.pop_front();
      end else if (mBufQ.size() != 0) begin
         if (redir) begin
            mPc = tgt;
            mBufQ.delete();
         end else if (!stall) begin
            mPc = mPc + 4;
            void'(mBufQ.pop_front());
         end
      end else begin
         if (redir) begin
            if (xfer) mPc = tgt;
            else mRedirQ.push_back(tgt);
         end else if (xfer) begin
            if (stall) mBufQ.push_back(data);
            else mPc = mPc + 4;
         end
      end
   endtask

   // Drive one cycle of inputs, compare DUT against the model, advance model.
   task automatic doCycle(input logic rst, input logic stF, input logic stD, input logic src,
                          input logic [31:0] tgt, input logic rdy, input logic [31:0] data);
      logic        expReq;
      logic [1:0]  expState;
      @(negedge clk);
      reset            = rst;
      StallF           = stF;
      StallD           = stD;
      PCSrcD           = src;
      PCBranchD        = tgt;
      memIf.InstrRdy   = rdy;
      memIf.InstrRdata = data;
      #1;
      expReq   = !rst && (mBufQ.size() == 0);
      expState = (mBufQ.size() != 0) ? 2'd1 : (mRedirQ.size() != 0) ? 2'd2 : 2'd0;
      checkVal("InstrReq", 32'(memIf.InstrReq), 32'(expReq));
      if (expReq) checkVal("InstrAddr", memIf.InstrAddr, mPc);
      checkVal("InstrD", InstrD, mInstrD);
      checkVal("PCPlus4D", PCPlus4D, mPcPlus4D);
      checkVal("ValidD", 32'(ValidD), 32'(mValidD));
      checkVal("state", 32'(stateDbg), 32'(expState));
      modelStep(rst, stF, stD, src, tgt, rdy, data);
   endtask

   task automatic idle(input logic rdy, input logic [31:0] data);
      doCycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, rdy, data);
   endtask

   // Main sequence: reset, directed scenarios, random traffic, report.
   initial begin
      reset = 1'b1; StallF = 0; StallD = 0; PCSrcD = 0; PCBranchD = 0;
      memIf.InstrRdy = 0; memIf.InstrRdata = 0;
      modelReset();
      repeat (2) @(posedge clk);
      // Reset cycle, with a late ready that must be ignored.
      doCycle(1'b1, 0, 0, 0, 32'd0, 1'b1, 32'hDEAD0000);

      // Streaming fetch: A0, A1, A2 at 0, 4, 8.
      idle(1'b1, 32'hA0);
      idle(1'b1, 32'hA1);
      idle(1'b1, 32'hA2);
      idle(1'b0, 32'd0);

      // Stall with a word returning at 0x10.
      doCycle(0, 0, 0, 1, 32'h10, 1'b1, 32'h0);
      doCycle(0, 1, 1, 0, 32'h0, 1'b1, 32'hB0);
      doCycle(0, 1, 1, 0, 32'h0, 1'b0, 32'h0);
      doCycle(0, 1, 1, 0, 32'h0, 1'b0, 32'h0);
      idle(1'b0, 32'h0);
      idle(1'b1, 32'hB1);
      idle(1'b0, 32'h0);

      // Branch while a request is outstanding: drain then redirect.
      doCycle(0, 0, 0, 1, 32'h20, 1'b1, 32'h0);
      doCycle(0, 0, 0, 1, 32'h100, 1'b0, 32'h0);
      idle(1'b0, 32'h0);
      idle(1'b1, 32'hBAD);
      idle(1'b1, 32'hC0);
      // Two targets during a drain: last one wins.
      doCycle(0, 0, 0, 1, 32'h200, 1'b0, 32'h0);
      doCycle(0, 0, 0, 1, 32'h300, 1'b0, 32'h0);
      idle(1'b1, 32'hBAD);
      idle(1'b1, 32'hC1);

      // Branch under StallD is ignored; without it the branch is taken.
      doCycle(0, 0, 1, 1, 32'h40, 1'b0, 32'h0);
      doCycle(0, 0, 0, 1, 32'h40, 1'b1, 32'h0);
      idle(1'b1, 32'hD0);

      // PC wrap at the top of the address space.
      doCycle(0, 0, 0, 1, 32'hFFFFFFFC, 1'b1, 32'h0);
      idle(1'b1, 32'hE0);
      idle(1'b1, 32'hE1);

      // Reset while parked in HOLD, then while draining.
      doCycle(0, 1, 1, 0, 32'h0, 1'b1, 32'hF0);
      doCycle(1, 0, 0, 0, 32'h0, 1'b1, 32'hF1);
      idle(1'b1, 32'hF2);
      doCycle(0, 0, 0, 1, 32'h80, 1'b0, 32'h0);
      doCycle(1, 0, 0, 0, 32'h0, 1'b1, 32'hF3);
      idle(1'b1, 32'hF4);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         logic        rst, stF, stD, src, rdy;
         logic [31:0] tgt;
         rst = ($urandom_range(0, 99) == 0);
         stF = ($urandom_range(0, 4) == 0);
         stD = ($urandom_range(0, 4) == 0);
         src = ($urandom_range(0, 9) == 0);
         rdy = ($urandom_range(0, 9) < 6);
         tgt = ($urandom_range(0, 19) == 0) ? 32'hFFFFFFFC : {$urandom(), 2'b00} >> 2 << 2;
         doCycle(rst, stF, stD, src, tgt, rdy, $urandom());
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
